// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller:
// FSM state encodings and the hardwired-zero register index.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HAZ   = 2'd1,
    MWAIT = 2'd2,
    FLUSH = 2'd3
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freeze on data hazards and memory waits, flush on taken branches.
// Define FORWARDING_EN to restrict data hazards to load-use only.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             id_src1,
  input  logic [4:0]             id_src2,
  input  logic                   id_two_src,
  input  logic [4:0]             exe_dest,
  input  logic                   exe_wb_en,
  input  logic                   exe_mem_r_en,
  input  logic [4:0]             mem_dest,
  input  logic                   mem_wb_en,
  input  logic                   br_taken,
  input  logic                   mem_ready,
  output logic                   freeze,
  output logic                   flush,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] FC_LOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [STALL_CNT_W-1:0] ONE = STALL_CNT_W'(1);

  hz_state_t  st, st_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       hazard;
  logic       mwait;

  function automatic logic match(
    input logic [4:0] d,
    input logic       en,
    input logic [4:0] s1,
    input logic [4:0] s2,
    input logic       two
  );
    return en && (d != REG_ZERO) &&
           ((d == s1) || (two && (d == s2)));
  endfunction

`ifdef FORWARDING_EN
  logic unused_mem;
  assign unused_mem = ^{mem_dest, mem_wb_en};
  assign hazard = match(exe_dest, exe_wb_en && exe_mem_r_en,
                        id_src1, id_src2, id_two_src);
`else
  logic unused_ld;
  assign unused_ld = exe_mem_r_en;
  assign hazard = match(exe_dest, exe_wb_en,
                        id_src1, id_src2, id_two_src) ||
                  match(mem_dest, mem_wb_en,
                        id_src1, id_src2, id_two_src);
`endif

  assign mwait = !mem_ready;
  assign state = st;

  // A nonzero counter means a flush is pending, even after a memory wait.
  always_comb begin
    freeze  = 1'b0;
    flush   = 1'b0;
    st_nxt  = RUN;
    cnt_nxt = cnt;
    if (mwait) begin
      freeze = 1'b1;
      st_nxt = MWAIT;
    end else if (br_taken) begin
      flush   = 1'b1;
      cnt_nxt = FC_LOAD;
      st_nxt  = (FC_LOAD != 2'd0) ? FLUSH : RUN;
    end else if (cnt != 2'd0) begin
      flush   = 1'b1;
      cnt_nxt = cnt - 2'd1;
      st_nxt  = (cnt != 2'd1) ? FLUSH : RUN;
    end else if (hazard) begin
      freeze = 1'b1;
      st_nxt = HAZ;
    end
    if (!rst) begin
      freeze = 1'b0;
      flush  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st        <= RUN;
      cnt       <= 2'd0;
      stall_cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      if (freeze && (stall_cnt != '1))
        stall_cnt <= stall_cnt + ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic
// checked against a rule-level reference model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int FC = 3;
  localparam int SW = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_src1, id_src2, exe_dest, mem_dest;
  logic          id_two_src, exe_wb_en, exe_mem_r_en;
  logic          mem_wb_en, br_taken, mem_ready;
  logic          freeze, flush;
  logic [1:0]    state;
  logic [SW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(FC), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .br_taken(br_taken), .mem_ready(mem_ready),
    .freeze(freeze), .flush(flush),
    .state(state), .stall_cnt(stall_cnt)
  );

  typedef struct {
    bit       rst;
    bit [4:0] s1, s2;
    bit       two;
    bit [4:0] ed;
    bit       ew, er;
    bit [4:0] md;
    bit       mw, br, mr;
  } vec_t;

  typedef struct {
    bit    fz, fl;
    int    st, sc;
    string tag;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: flush cycles still owed, state, stall total
  int m_left = 0;
  int m_state = 0;
  int m_stalls = 0;

  function automatic bit match(bit [4:0] d, bit en, vec_t v);
    return en && d != 0 && (d == v.s1 || (v.two && d == v.s2));
  endfunction

  function automatic vec_t idle();
    vec_t v;
    v = '{rst: 1, s1: 0, s2: 0, two: 0, ed: 0, ew: 0, er: 0,
          md: 0, mw: 0, br: 0, mr: 1};
    return v;
  endfunction

  task automatic chk(string name, string tag, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s [%s]: got %0d, expected %0d", name, tag, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    bit   hz;
    @(posedge clk);
    #1;
    rst = v.rst; id_src1 = v.s1; id_src2 = v.s2; id_two_src = v.two;
    exe_dest = v.ed; exe_wb_en = v.ew; exe_mem_r_en = v.er;
    mem_dest = v.md; mem_wb_en = v.mw;
    br_taken = v.br; mem_ready = v.mr;
`ifdef FORWARDING_EN
    hz = match(v.ed, v.ew && v.er, v);
`else
    hz = match(v.ed, v.ew, v) || match(v.md, v.mw, v);
`endif
    e.fz = 0;
    e.fl = 0;
    if (!v.rst) begin
      m_left = 0; m_state = 0; m_stalls = 0;
    end else if (!v.mr) begin
      e.fz = 1; m_state = 2;
    end else if (v.br) begin
      e.fl = 1; m_left = FC - 1;
      m_state = (m_left > 0) ? 3 : 0;
    end else if (m_left > 0) begin
      e.fl = 1; m_left--;
      m_state = (m_left > 0) ? 3 : 0;
    end else if (hz) begin
      e.fz = 1; m_state = 1;
    end else begin
      m_state = 0;
    end
    if (e.fz && m_stalls < SMAX) m_stalls++;
    e.st = m_state;
    e.sc = m_stalls;
    e.tag = tag;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() == 0) continue;
      e = q.pop_front();
      chk("freeze", e.tag, int'(freeze === 1'b1), int'(e.fz));
      chk("flush", e.tag, int'(flush === 1'b1), int'(e.fl));
      chk("excl", e.tag, int'(freeze === 1'b1 && flush === 1'b1), 0);
      @(posedge clk);
      #2;
      chk("state", e.tag, int'(state), e.st);
      chk("stall_cnt", e.tag, int'(stall_cnt), e.sc);
    end
  end

  initial begin
    vec_t v;
    v = idle(); v.rst = 0;
    apply(v, "reset"); apply(v, "reset");
    apply(idle(), "idle");

    v = idle(); v.ed = 3; v.ew = 1; v.er = 1; v.s1 = 3;
    apply(v, "load_use");
    apply(idle(), "after_load");

    v = idle(); v.md = 3; v.mw = 1; v.s2 = 3; v.two = 1;
    apply(v, "mem_alu_src2");
    v.two = 0;
    apply(v, "mem_alu_one_src");

    v = idle(); v.ed = 0; v.ew = 1; v.s1 = 0;
    apply(v, "reg0");

    v = idle(); v.br = 1;
    apply(v, "br1");
    repeat (4) apply(idle(), "br1_tail");
    apply(v, "br2");
    apply(idle(), "br2_c2");
    apply(v, "br2_restart");
    repeat (4) apply(idle(), "br2_tail");

    v = idle(); v.rst = 0;
    apply(v, "reset2");
    v = idle(); v.mr = 0; v.br = 1; v.ed = 3; v.ew = 1; v.er = 1; v.s1 = 3;
    repeat (4) apply(v, "mwait_br_haz");
    v.mr = 1;
    apply(v, "mready_br");
    v.br = 0; v.ed = 0;
    repeat (3) apply(v, "post_mwait");

    v = idle(); v.br = 1;
    apply(v, "br_mid");
    apply(idle(), "flush_c2");
    v = idle(); v.mr = 0;
    repeat (2) apply(v, "mwait_mid_flush");
    repeat (3) apply(idle(), "flush_resume");

    v = idle(); v.br = 1;
    apply(v, "br_pre_rst");
    v.mr = 0;
    apply(v, "mwait_in_flush");
    v.rst = 0;
    apply(v, "rst_mid");
    apply(idle(), "after_rst");

    v = idle(); v.ed = 2; v.ew = 1; v.er = 1; v.s1 = 2;
    repeat (20) apply(v, "saturate");
    apply(idle(), "sat_idle");

    for (int i = 0; i < 400; i++) begin
      v.rst = ($urandom_range(0, 19) != 0);
      v.s1  = 5'($urandom_range(0, 3));
      v.s2  = 5'($urandom_range(0, 3));
      v.two = 1'($urandom);
      v.ed  = 5'($urandom_range(0, 3));
      v.ew  = 1'($urandom);
      v.er  = 1'($urandom);
      v.md  = 5'($urandom_range(0, 3));
      v.mw  = 1'($urandom);
      v.br  = ($urandom_range(0, 7) == 0);
      v.mr  = ($urandom_range(0, 4) != 0);
      apply(v, "random");
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", "end", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, legal 1..3: consecutive cycles flush is held per taken branch.
REQ-002 SHALL have parameter STALL_CNT_W, default 16: width of stall_cnt.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-low.
REQ-005 SHALL have ports id_src1, id_src2  in  5 each  source registers of the instruction in ID.
REQ-006 SHALL have port id_two_src  in  1  id_src2 is a real read (R-type/store/branch).
REQ-007 SHALL have ports exe_dest, exe_wb_en, exe_mem_r_en  in  5/1/1  destination, writeback enable and load flag of the instruction in EXE.
REQ-008 SHALL have ports mem_dest, mem_wb_en  in  5/1  destination and writeback enable of the instruction in MEM.
REQ-009 SHALL have ports br_taken  in  1  branch resolved taken in EXE; mem_ready  in  1  data memory done (0 = wait).
REQ-010 SHALL have ports freeze  out  1  hold PC and IF/ID registers; flush  out  1  clear IF and ID stage registers.
REQ-011 SHALL have ports state  out  2  FSM state; stall_cnt  out  STALL_CNT_W  saturating count of freeze cycles.

Function
REQ-012 SHALL define match(d, en) = en AND d != 0 AND (d == id_src1 OR (id_two_src AND d == id_src2)); register 0 never hazards.
REQ-013 SHALL define hazard per the Configuration section; mwait = NOT mem_ready.
REQ-014 SHALL implement FSM RUN=0, HAZ=1, MWAIT=2, FLUSH=3, priority mwait > br_taken > hazard.
REQ-015 SHALL, in any state when mwait: next=MWAIT, freeze=1, flush=0; br_taken and hazard are ignored that cycle (whole pipe is held).
REQ-016 SHALL, when not mwait and br_taken: flush=1, freeze=0, load flush counter with FLUSH_CYCLES-1, next=FLUSH if FLUSH_CYCLES>1, else RUN.
REQ-017 SHALL, in FLUSH without mwait/br_taken: flush=1, freeze=0, decrement counter, return to RUN when counter reaches 0; hazard is ignored (ID instruction is killed).
REQ-018 SHALL restart the flush counter at FLUSH_CYCLES-1 on a br_taken arriving in FLUSH.
REQ-019 SHALL, otherwise, when hazard: freeze=1, flush=0, next=HAZ; when no hazard: freeze=0, flush=0, next=RUN.
REQ-020 SHALL keep the flush counter frozen during MWAIT and resume FLUSH afterwards if the counter is nonzero.
REQ-021 SHALL produce freeze and flush combinationally in the same cycle as the causing inputs (zero latency); state and stall_cnt are registered.
REQ-022 SHALL never assert freeze and flush together.
REQ-023 SHALL increment stall_cnt by 1 each cycle freeze=1, saturating at all-ones.

Reset
REQ-024 SHALL, on rising clk with rst=0: state=RUN, flush counter=0, stall_cnt=0; freeze=0 and flush=0 while rst=0, overriding all inputs, including mid-flush or mid-wait.

Configuration
REQ-025 SHALL, with FORWARDING_EN defined: hazard = match(exe_dest, exe_wb_en AND exe_mem_r_en) (load-use only).
REQ-026 SHALL, without FORWARDING_EN: hazard = match(exe_dest, exe_wb_en) OR match(mem_dest, mem_wb_en).

Structure
REQ-027 SHALL place the FSM state encodings and the register-0 constant in the shared pipeline package.
REQ-028 SHALL be implemented as one module; comparator logic is inline, with no sub-module.

Verification
REQ-029 SHALL cover: load r3 in EXE (exe_mem_r_en=1, exe_wb_en=1, exe_dest=3), id_src1=3 -> freeze=1 one cycle, state=HAZ, stall_cnt=1.
REQ-030 SHALL cover: ALU r3 in MEM, id_src2=3, id_two_src=1 -> freeze=0 with FORWARDING_EN, freeze=1 without; id_two_src=0 -> freeze=0 in both.
REQ-031 SHALL cover: exe_dest=0, exe_wb_en=1, id_src1=0 -> freeze=0.
REQ-032 SHALL cover: FLUSH_CYCLES=3, br_taken pulse -> flush=1 for exactly 3 cycles; second br_taken in cycle 2 -> 3 more cycles from there.
REQ-033 SHALL cover: mem_ready=0 for 4 cycles with br_taken=1 and hazard active -> freeze=1, flush=0 for 4 cycles, stall_cnt=4; then flush begins the cycle mem_ready=1.
REQ-034 SHALL cover: rst=0 asserted in FLUSH with mem_ready=0 -> next cycle state=0, stall_cnt=0, freeze=0, flush=0.
